// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_pkg
// Purpose  : Shared definitions for the single-byte AXI DMA core: bus
//            geometry, AXI response codes and the transfer state encoding.
// Contents : ADDR_W / DATA_W / BYTE_W / LANE_W geometry constants,
//            RESP_OKAY / RESP_SLVERR response codes, state_t enum.
// Revision : 1.0 - initial release
// ============================================================================
package axi_pkg;

    // Bus geometry (fixed: 32-bit address, 64-bit data, byte lanes)
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int BYTE_W = 8;
    localparam int LANES  = DATA_W / BYTE_W;
    localparam int LANE_W = 3;
    localparam int STRB_W = LANES;

    // AXI response codes; the core completes regardless of the value
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Transfer sequencing
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

endpackage : axi_pkg
`default_nettype wire

// File: rtl/axi_byte_io_core_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_byte_io_core_if
// Purpose  : Single-beat AXI4 read/write channel bundle used between the
//            byte DMA core (master) and system memory (slave).
// Signals  : AR  araddr / arvalid / arready
//            R   rdata / rresp / rvalid / rready
//            AW  awaddr / awvalid / awready
//            W   wdata / wstrb / wvalid / wready
//            B   bresp / bvalid / bready
// Modports : master (DMA side), slave (memory side)
// Revision : 1.0 - initial release
// ============================================================================
interface axi_byte_io_core_if;
    import axi_pkg::*;

    // Read address channel
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    // Read data channel
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    // Write address channel
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    // Write data channel
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    // Write response channel
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

endinterface : axi_byte_io_core_if
`default_nettype wire

// File: rtl/axi_byte_io_core.sv
`default_nettype none
// ============================================================================
// Module   : axi_byte_io_core
// Purpose  : Single-byte DMA engine. Each start performs exactly one byte
//            read or one byte write as a single-beat AXI access on a 64-bit
//            bus, then pulses done.
// Ports    : aclk        in   clock, rising edge
//            areset      in   synchronous active-high reset
//            busy        out  transfer in progress (includes the done cycle)
//            write       in   1 = write data_write, 0 = read into data_read
//            addr        in   byte address (sampled on start)
//            data_read   out  byte returned by the last completed read
//            data_write  in   byte to write (sampled on start)
//            start       in   one-cycle request pulse, honoured only when idle
//            done        out  one-cycle completion pulse
//            m_axi       AXI master channel bundle
// Revision : 1.0 - initial release
// ============================================================================
module axi_byte_io_core
    import axi_pkg::*;
(
    input  logic                aclk,
    input  logic                areset,
    output logic                busy,
    input  logic                write,
    input  logic [ADDR_W-1:0]   addr,
    output logic [BYTE_W-1:0]   data_read,
    input  logic [BYTE_W-1:0]   data_write,
    input  logic                start,
    output logic                done,
    axi_byte_io_core_if.master  m_axi
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [BYTE_W-1:0]   wbyte_q,     wbyte_d;
    logic                aw_done_q,   aw_done_d;   // AW handshake already taken
    logic                w_done_q,    w_done_d;    // W handshake already taken
    logic [BYTE_W-1:0]   data_read_q, data_read_d;
    logic                done_q,      done_d;

    logic [LANE_W-1:0]   lane;
    logic                aw_fin;
    logic                w_fin;
    logic                unused_resp;

    assign lane = addr_q[LANE_W-1:0];

    // Response codes carry no meaning for this core: an error still completes.
    assign unused_resp = ^{m_axi.rresp, m_axi.bresp};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wbyte_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            data_read_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wbyte_q     <= wbyte_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            data_read_q <= data_read_d;
            done_q      <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wbyte_d     = wbyte_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        data_read_d = data_read_q;
        done_d      = 1'b0;
        // A channel counts as finished once its handshake has happened,
        // either in an earlier cycle or in this one.
        aw_fin      = aw_done_q | m_axi.awready;
        w_fin       = w_done_q  | m_axi.wready;

        case (state_q)
            ST_IDLE: begin
                // The done cycle still counts as busy, so a start coinciding
                // with done is dropped rather than queued.
                if (start && !done_q) begin
                    addr_d    = addr;
                    wbyte_d   = data_write;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = write ? ST_WR : ST_RD_ADDR;
                end
            end

            ST_RD_ADDR: begin
                if (m_axi.arready) begin
                    state_d = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                if (m_axi.rvalid) begin
                    data_read_d = m_axi.rdata[{lane, 3'b000} +: BYTE_W];
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            ST_WR: begin
                // AW and W complete independently and in any order.
                aw_done_d = aw_fin;
                w_done_d  = w_fin;
                if (aw_fin && w_fin) begin
                    state_d = ST_WR_RESP;
                end
            end

            ST_WR_RESP: begin
                if (m_axi.bvalid) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // AXI outputs: all derived from registered state, so address and data
    // stay stable for as long as a valid is held.
    // ------------------------------------------------------------------
    assign m_axi.araddr  = {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
    assign m_axi.arvalid = (state_q == ST_RD_ADDR);
    assign m_axi.rready  = (state_q == ST_RD_DATA);

    assign m_axi.awaddr  = {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
    assign m_axi.awvalid = (state_q == ST_WR) && !aw_done_q;
    assign m_axi.wvalid  = (state_q == ST_WR) && !w_done_q;
    // Byte replicated across every lane; the strobe selects the one written.
    assign m_axi.wdata   = {LANES{wbyte_q}};
    assign m_axi.wstrb   = {{(STRB_W-1){1'b0}}, 1'b1} << lane;
    assign m_axi.bready  = (state_q == ST_WR_RESP);

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    assign busy      = (state_q != ST_IDLE) || done_q;
    assign done      = done_q;
    assign data_read = data_read_q;

endmodule : axi_byte_io_core
`default_nettype wire

// File: tb/tb_axi_byte_io_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_byte_io_core
// Purpose  : Self-checking bench for axi_byte_io_core. A responsive AXI slave
//            model with per-channel latency knobs; expected addresses, write
//            data/strobes and read bytes are queued when a transfer is issued
//            and popped by an independent monitor on each handshake / done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_byte_io_core;
    import axi_pkg::*;

    logic        aclk = 1'b0;
    logic        areset;
    logic        busy;
    logic        write;
    logic [31:0] addr;
    logic [7:0]  data_read;
    logic [7:0]  data_write;
    logic        start;
    logic        done;

    axi_byte_io_core_if m_axi();

    axi_byte_io_core dut (
        .aclk       (aclk),
        .areset     (areset),
        .busy       (busy),
        .write      (write),
        .addr       (addr),
        .data_read  (data_read),
        .data_write (data_write),
        .start      (start),
        .done       (done),
        .m_axi      (m_axi)
    );

    always #5 aclk = ~aclk;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_total = 0;

    // Slave latency knobs
    int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [63:0] rdata_cfg = '0;
    logic [1:0]  rresp_cfg = RESP_OKAY;
    logic [1:0]  bresp_cfg = RESP_OKAY;

    // Scoreboard queues
    logic [31:0] exp_ar_q[$];
    logic [31:0] exp_aw_q[$];
    logic [63:0] exp_wdata_q[$];
    logic [7:0]  exp_wstrb_q[$];
    logic [7:0]  exp_done_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // AXI slave model: handshakes sampled mid-cycle, responses driven
    // just after the rising edge.
    // ------------------------------------------------------------------
    initial begin : slave
        bit hs_ar, hs_r, hs_aw, hs_w, hs_b;
        bit r_pend, aw_seen, w_seen, b_pend;
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        m_axi.arready = 0; m_axi.rvalid = 0; m_axi.rdata = '0; m_axi.rresp = '0;
        m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0; m_axi.bresp = '0;
        r_pend = 0; aw_seen = 0; w_seen = 0; b_pend = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        forever begin
            @(negedge aclk);
            hs_ar = m_axi.arvalid && m_axi.arready;
            hs_r  = m_axi.rvalid  && m_axi.rready;
            hs_aw = m_axi.awvalid && m_axi.awready;
            hs_w  = m_axi.wvalid  && m_axi.wready;
            hs_b  = m_axi.bvalid  && m_axi.bready;
            @(posedge aclk);
            #1;
            if (areset) begin
                m_axi.arready = 0; m_axi.rvalid = 0; m_axi.awready = 0;
                m_axi.wready = 0;  m_axi.bvalid = 0;
                r_pend = 0; aw_seen = 0; w_seen = 0; b_pend = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
                continue;
            end
            // R channel
            if (hs_r) begin
                m_axi.rvalid = 0;
                m_axi.rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            if (hs_ar) begin r_pend = 1; r_cnt = 0; end
            if (r_pend) begin
                if (r_cnt >= r_delay) begin
                    m_axi.rvalid = 1; m_axi.rdata = rdata_cfg; m_axi.rresp = rresp_cfg;
                    r_pend = 0;
                end else r_cnt++;
            end
            // AR channel
            if (m_axi.arvalid) begin m_axi.arready = (ar_cnt >= ar_delay); ar_cnt++; end
            else begin m_axi.arready = 0; ar_cnt = 0; end
            // AW / W channels
            if (m_axi.awvalid) begin m_axi.awready = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin m_axi.awready = 0; aw_cnt = 0; end
            if (m_axi.wvalid) begin m_axi.wready = (w_cnt >= w_delay); w_cnt++; end
            else begin m_axi.wready = 0; w_cnt = 0; end
            // B channel
            if (hs_b) m_axi.bvalid = 0;
            if (hs_aw) aw_seen = 1;
            if (hs_w)  w_seen  = 1;
            if (aw_seen && w_seen) begin b_pend = 1; b_cnt = 0; aw_seen = 0; w_seen = 0; end
            if (b_pend) begin
                if (b_cnt >= b_delay) begin
                    m_axi.bvalid = 1; m_axi.bresp = bresp_cfg; b_pend = 0;
                end else b_cnt++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: pops expectations on every handshake and done pulse
    // ------------------------------------------------------------------
    initial begin : monitor
        logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_rst;
        logic [31:0] p_araddr, p_awaddr;
        logic [63:0] p_wdata;
        logic [7:0]  p_wstrb;
        p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_rst = 1;
        p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0;
        forever begin
            @(negedge aclk);
            if (!p_rst && !areset) begin
                if (p_arv && !p_arr)
                    check("ar_hold", {m_axi.arvalid, m_axi.araddr}, {1'b1, p_araddr});
                if (p_awv && !p_awr)
                    check("aw_hold", {m_axi.awvalid, m_axi.awaddr}, {1'b1, p_awaddr});
                if (p_wv && !p_wr)
                    check("w_hold", {m_axi.wvalid, m_axi.wstrb, m_axi.wdata[31:0]},
                          {1'b1, p_wstrb, p_wdata[31:0]});
            end
            if (m_axi.arvalid || m_axi.rready || m_axi.awvalid || m_axi.wvalid || m_axi.bready)
                check("busy_active", busy, 1'b1);
            if (m_axi.arvalid && m_axi.arready) begin
                if (exp_ar_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_ar: araddr 0x%0h, none expected", m_axi.araddr);
                end else check("araddr", m_axi.araddr, exp_ar_q.pop_front());
            end
            if (m_axi.awvalid && m_axi.awready) begin
                if (exp_aw_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_aw: awaddr 0x%0h, none expected", m_axi.awaddr);
                end else check("awaddr", m_axi.awaddr, exp_aw_q.pop_front());
            end
            if (m_axi.wvalid && m_axi.wready) begin
                if (exp_wdata_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_w: wdata 0x%0h, none expected", m_axi.wdata);
                end else begin
                    check("wdata", m_axi.wdata, exp_wdata_q.pop_front());
                    check("wstrb", m_axi.wstrb, exp_wstrb_q.pop_front());
                end
            end
            if (done) begin
                done_total++;
                if (exp_done_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_done: done with data_read 0x%0h, none expected", data_read);
                end else begin
                    check("data_read", data_read, exp_done_q.pop_front());
                    check("busy_on_done", busy, 1'b1);
                end
            end
            p_arv = m_axi.arvalid; p_arr = m_axi.arready; p_araddr = m_axi.araddr;
            p_awv = m_axi.awvalid; p_awr = m_axi.awready; p_awaddr = m_axi.awaddr;
            p_wv  = m_axi.wvalid;  p_wr  = m_axi.wready;
            p_wdata = m_axi.wdata; p_wstrb = m_axi.wstrb;
            p_rst = areset;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic issue(input bit wr, input logic [31:0] a, input logic [7:0] d);
        @(posedge aclk); #2;
        write = wr; addr = a; data_write = d; start = 1;
        @(posedge aclk); #2;
        // Scramble inputs so late sampling would be visible
        start = 0; write = ~wr; addr = 32'hFFFF_FFFF; data_write = ~d;
        @(negedge aclk);
        check("busy_after_start", busy, 1'b1);
        if (wr) check("wr_valids_after_start", {m_axi.awvalid, m_axi.wvalid}, 2'b11);
        else    check("arvalid_after_start", m_axi.arvalid, 1'b1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 60) begin
            @(negedge aclk);
            n++;
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: done not seen in %0d cycles", name, n);
        end
    endtask

    task automatic check_idle_next(input string name);
        @(negedge aclk);
        check({name, "_busy_low"}, busy, 1'b0);
        check({name, "_done_single"}, done, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : stim
        int n;
        areset = 1; start = 0; write = 0; addr = '0; data_write = '0;
        repeat (3) @(negedge aclk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data_read", data_read, 8'h00);
        check("rst_valids", {m_axi.arvalid, m_axi.rready, m_axi.awvalid, m_axi.wvalid, m_axi.bready}, 5'b0);
        @(posedge aclk); #2 areset = 0;

        // 1: read, lane 3, immediate slave
        ar_delay = 0; r_delay = 0; rdata_cfg = 64'h8877665544332211; rresp_cfg = RESP_OKAY;
        exp_ar_q.push_back(32'h0000_1000); exp_done_q.push_back(8'h44);
        issue(0, 32'h0000_1003, 8'h00);
        wait_done("read1");
        check_idle_next("read1");

        // 2: write, lane 7
        aw_delay = 0; w_delay = 0; b_delay = 0; bresp_cfg = RESP_OKAY;
        exp_aw_q.push_back(32'h0000_2000);
        exp_wdata_q.push_back(64'hA5A5A5A5A5A5A5A5); exp_wstrb_q.push_back(8'h80);
        exp_done_q.push_back(8'h44);
        issue(1, 32'h0000_2007, 8'hA5);
        wait_done("write1");
        check_idle_next("write1");

        // 3: write back-pressure, with a stray start while busy
        aw_delay = 0; w_delay = 3; b_delay = 5;
        exp_aw_q.push_back(32'h0000_3000);
        exp_wdata_q.push_back(64'h3C3C3C3C3C3C3C3C); exp_wstrb_q.push_back(8'h04);
        exp_done_q.push_back(8'h44);
        issue(1, 32'h0000_3002, 8'h3C);
        @(posedge aclk); #2;
        write = 0; addr = 32'h0000_9000; start = 1;
        @(posedge aclk); #2 start = 0;
        wait_done("write_bp");

        // 4: read started the cycle right after done, lane 0
        rdata_cfg = 64'h0123456789ABCDEF;
        exp_ar_q.push_back(32'h0000_4000); exp_done_q.push_back(8'hEF);
        issue(0, 32'h0000_4000, 8'h00);
        wait_done("read_b2b");
        check_idle_next("read_b2b");

        // 5: reset while waiting in the read-data phase
        r_delay = 30;
        exp_ar_q.push_back(32'h0000_5000);
        issue(0, 32'h0000_5005, 8'h00);
        n = 0;
        while (!m_axi.rready && n < 10) begin @(negedge aclk); n++; end
        check("reached_rd_data", m_axi.rready, 1'b1);
        @(posedge aclk); #2 areset = 1;
        @(posedge aclk); #2 areset = 0;
        @(negedge aclk);
        check("rst_mid_valids", {m_axi.arvalid, m_axi.rready}, 2'b00);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_data_read", data_read, 8'h00);
        repeat (35) @(negedge aclk);

        // 6: read after reset, lane 6, delayed slave
        ar_delay = 2; r_delay = 3; rdata_cfg = 64'hFEDCBA9876543210;
        exp_ar_q.push_back(32'h0000_6000); exp_done_q.push_back(8'hDC);
        issue(0, 32'h0000_6006, 8'h00);
        wait_done("read_after_rst");
        check_idle_next("read_after_rst");

        // 7: read with SLVERR, lane 1
        ar_delay = 0; r_delay = 1; rdata_cfg = 64'h1122334455667788; rresp_cfg = RESP_SLVERR;
        exp_ar_q.push_back(32'h0000_7000); exp_done_q.push_back(8'h77);
        issue(0, 32'h0000_7001, 8'h00);
        wait_done("read_slverr");
        check_idle_next("read_slverr");

        // 8: write with SLVERR, lane 0, AW later than W
        aw_delay = 2; w_delay = 0; b_delay = 1; bresp_cfg = RESP_SLVERR;
        exp_aw_q.push_back(32'h0000_8000);
        exp_wdata_q.push_back(64'h5A5A5A5A5A5A5A5A); exp_wstrb_q.push_back(8'h01);
        exp_done_q.push_back(8'h77);
        issue(1, 32'h0000_8000, 8'h5A);
        wait_done("write_slverr");
        check_idle_next("write_slverr");

        repeat (5) @(negedge aclk);
        check("done_count", done_total, 7);
        check("queues_drained", exp_ar_q.size() + exp_aw_q.size() + exp_wdata_q.size()
              + exp_done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_axi_byte_io_core
`default_nettype wire
